// File: rtl/hit_pkg.sv
// -----------------------------------------------------------------------------
// hit_pkg
// Shared definitions for the player hit-tracking blocks.
//   hit_state_e             : player life-cycle state (ALIVE / COOLDOWN / DEAD)
//   DEFAULT_MAX_HEALTH      : health loaded at reset and on respawn
//   DEFAULT_COOLDOWN_FRAMES : invincibility window length in frames
//   DEFAULT_BLINK_FRAMES    : visibility toggle period during the window
//   frames_to_load()        : converts a frame count into a down-counter load value
// -----------------------------------------------------------------------------
package hit_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_DEAD     = 2'd2
  } hit_state_e;

  localparam int DEFAULT_MAX_HEALTH      = 3;
  localparam int DEFAULT_COOLDOWN_FRAMES = 60;
  localparam int DEFAULT_BLINK_FRAMES    = 8;

  // A down-counter that expires on zero must be loaded with N-1 to last N frames.
  function automatic logic [7:0] frames_to_load(input int frames);
    return 8'(frames - 1);
  endfunction

endpackage : hit_pkg

// File: rtl/aabb_overlap.sv
// -----------------------------------------------------------------------------
// aabb_overlap
// Purely combinational axis-aligned box overlap test between two squares given
// by centre and half-size. Uses only additions so no unsigned wrap-around from
// subtraction can occur; the sums are evaluated in 11 bits.
// Ports:
//   ax, ay, as : box A centre X/Y and half-size (10 bits each)
//   bx, by, bs : box B centre X/Y and half-size (10 bits each)
//   overlap    : 1 when the boxes touch or intersect (edges inclusive)
// -----------------------------------------------------------------------------
module aabb_overlap (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] as,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] bs,
  output logic       overlap
);

  logic [10:0] a_reach_x_s;
  logic [10:0] b_reach_x_s;
  logic [10:0] a_reach_y_s;
  logic [10:0] b_reach_y_s;

  // Centre of one box plus both half-sizes must reach the centre of the other,
  // in both directions and on both axes.
  always_comb begin
    a_reach_x_s = {1'b0, ax} + {1'b0, as} + {1'b0, bs};
    b_reach_x_s = {1'b0, bx} + {1'b0, bs} + {1'b0, as};
    a_reach_y_s = {1'b0, ay} + {1'b0, as} + {1'b0, bs};
    b_reach_y_s = {1'b0, by} + {1'b0, bs} + {1'b0, as};
    overlap     = (a_reach_x_s >= {1'b0, bx}) &&
                  (b_reach_x_s >= {1'b0, ax}) &&
                  (a_reach_y_s >= {1'b0, by}) &&
                  (b_reach_y_s >= {1'b0, ay});
  end

endmodule : aabb_overlap

// File: rtl/player_hit_tracker.sv
// -----------------------------------------------------------------------------
// player_hit_tracker
// Tracks hits of the opponent bullet on a player, health, a post-hit
// invincibility window with blinking, death and respawn.
// Parameters:
//   MAX_HEALTH      : health at reset and respawn (1..7)
//   COOLDOWN_FRAMES : invincibility window after a hit or respawn (1..255)
//   BLINK_FRAMES    : visibility toggle period during the window
// Ports:
//   frame_clk                 : frame clock, all logic on its rising edge
//   Reset                     : synchronous active-high reset
//   BulletX/BulletY/BulletS   : opponent bullet centre and half-size
//   bullet_on                 : opponent bullet is live
//   BallX/BallY/BallS         : this player's centre and half-size
//   respawn                   : level request to revive a dead player
//   hit_pulse                 : one-frame strobe per accepted hit
//   bullet_kill               : tells the bullet owner to retire the bullet
//   health                    : remaining health
//   invincible/player_dead    : state is COOLDOWN / DEAD
//   player_visible            : draw enable (blinks during COOLDOWN)
// -----------------------------------------------------------------------------
module player_hit_tracker
  import hit_pkg::*;
#(
  parameter int MAX_HEALTH      = DEFAULT_MAX_HEALTH,
  parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES,
  parameter int BLINK_FRAMES    = DEFAULT_BLINK_FRAMES
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] BulletS,
  input  logic       bullet_on,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  input  logic       respawn,
  output logic       hit_pulse,
  output logic       bullet_kill,
  output logic [2:0] health,
  output logic       invincible,
  output logic       player_dead,
  output logic       player_visible
);

  localparam logic [2:0] HEALTH_FULL = 3'(MAX_HEALTH);
  localparam logic [7:0] CD_LOAD     = frames_to_load(COOLDOWN_FRAMES);
  localparam logic [7:0] BLINK_LOAD  = frames_to_load(BLINK_FRAMES);

  hit_state_e state_q, state_d;
  logic [2:0] health_q, health_d;
  logic       hit_pulse_q, hit_pulse_d;
  logic       armed_q, armed_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;

  logic       overlap_s;
  logic       accept_s;

  aabb_overlap u_overlap (
    .ax      (BulletX),
    .ay      (BulletY),
    .as      (BulletS),
    .bx      (BallX),
    .by      (BallY),
    .bs      (BallS),
    .overlap (overlap_s)
  );

  // Hit acceptance, armed flag and state/health/counter next-state logic.
  always_comb begin
    accept_s    = (state_q == ST_ALIVE) && bullet_on && armed_q && overlap_s;

    state_d     = state_q;
    health_d    = health_q;
    cnt_d       = cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    hit_pulse_d = accept_s;

    // Re-arm only once the bullet has gone away, so one flight scores once.
    if (accept_s) begin
      armed_d = 1'b0;
    end else if (!bullet_on) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      ST_ALIVE: begin
        if (accept_s) begin
          if (health_q > 3'd1) begin
            state_d     = ST_COOLDOWN;
            health_d    = health_q - 3'd1;
            cnt_d       = CD_LOAD;
            blink_cnt_d = BLINK_LOAD;
            phase_d     = 1'b0;
          end else begin
            state_d     = ST_DEAD;
            health_d    = 3'd0;
            cnt_d       = 8'd0;
            blink_cnt_d = 8'd0;
            phase_d     = 1'b0;
          end
        end else begin
          state_d = ST_ALIVE;
        end
      end

      ST_COOLDOWN: begin
        if (cnt_q == 8'd0) begin
          state_d     = ST_ALIVE;
          blink_cnt_d = 8'd0;
          phase_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (blink_cnt_q == 8'd0) begin
            blink_cnt_d = BLINK_LOAD;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q - 8'd1;
          end
        end
      end

      ST_DEAD: begin
        if (respawn) begin
          state_d     = ST_COOLDOWN;
          health_d    = HEALTH_FULL;
          cnt_d       = CD_LOAD;
          blink_cnt_d = BLINK_LOAD;
          phase_d     = 1'b0;
        end else begin
          state_d = ST_DEAD;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a safe, fully healthy ALIVE.
        state_d     = ST_ALIVE;
        health_d    = HEALTH_FULL;
        cnt_d       = 8'd0;
        blink_cnt_d = 8'd0;
        phase_d     = 1'b0;
      end
    endcase
  end

  // All state flops; synchronous reset wins over every simultaneous event.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_ALIVE;
      health_q    <= HEALTH_FULL;
      hit_pulse_q <= 1'b0;
      armed_q     <= 1'b1;
      cnt_q       <= 8'd0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      health_q    <= health_d;
      hit_pulse_q <= hit_pulse_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Draw enable: steady when alive, blinking during the window, hidden when dead.
  always_comb begin
    case (state_q)
      ST_ALIVE:    player_visible = 1'b1;
      ST_COOLDOWN: player_visible = ~phase_q;
      ST_DEAD:     player_visible = 1'b0;
      default:     player_visible = 1'b0;
    endcase
  end

  assign hit_pulse   = hit_pulse_q;
  assign bullet_kill = hit_pulse_q;
  assign health      = health_q;
  assign invincible  = (state_q == ST_COOLDOWN);
  assign player_dead = (state_q == ST_DEAD);

endmodule : player_hit_tracker

// File: tb/tb_player_hit_tracker.sv
// -----------------------------------------------------------------------------
// tb_player_hit_tracker
// Directed self-checking bench for player_hit_tracker with default parameters
// (MAX_HEALTH=3, COOLDOWN_FRAMES=60, BLINK_FRAMES=8). Inputs change and
// outputs are sampled 1 time unit after each rising frame_clk edge.
// -----------------------------------------------------------------------------
module tb_player_hit_tracker;

  logic       frame_clk;
  logic       Reset;
  logic [9:0] BulletX, BulletY, BulletS;
  logic       bullet_on;
  logic [9:0] BallX, BallY, BallS;
  logic       respawn;
  logic       hit_pulse;
  logic       bullet_kill;
  logic [2:0] health;
  logic       invincible;
  logic       player_dead;
  logic       player_visible;

  int n_cmp = 0;
  int n_bad = 0;

  player_hit_tracker dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .BulletX        (BulletX),
    .BulletY        (BulletY),
    .BulletS        (BulletS),
    .bullet_on      (bullet_on),
    .BallX          (BallX),
    .BallY          (BallY),
    .BallS          (BallS),
    .respawn        (respawn),
    .hit_pulse      (hit_pulse),
    .bullet_kill    (bullet_kill),
    .health         (health),
    .invincible     (invincible),
    .player_dead    (player_dead),
    .player_visible (player_visible)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    respawn   = 1'b0;
    bullet_on = 1'b0;
    BallX     = 10'd320;
    BallY     = 10'd240;
    BallS     = 10'd8;
    BulletX   = 10'd333;
    BulletY   = 10'd240;
    BulletS   = 10'd4;
    step();
    step();
    Reset = 1'b0;

    // Reset state
    check("rst_health", 32'(health), 32'd3);
    check("rst_pulse", 32'(hit_pulse), 32'd0);
    check("rst_invincible", 32'(invincible), 32'd0);
    check("rst_dead", 32'(player_dead), 32'd0);
    check("rst_visible", 32'(player_visible), 32'd1);

    // Just outside the box: 320+8+4 = 332 < 333, no hit
    bullet_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("miss333_pulse", 32'(hit_pulse), 32'd0);
    end
    check("miss333_health", 32'(health), 32'd3);
    check("miss333_invincible", 32'(invincible), 32'd0);

    // Centre hit; armed still set since the miss never scored
    BulletX = 10'd324;
    step();
    check("hit1_pulse", 32'(hit_pulse), 32'd1);
    check("hit1_kill", 32'(bullet_kill), 32'd1);
    check("hit1_health", 32'(health), 32'd2);
    check("hit1_invincible", 32'(invincible), 32'd1);
    check("hit1_visible", 32'(player_visible), 32'd1);

    // Overlap held through the window: no pulses, blink every 8 frames
    for (int k = 2; k <= 60; k++) begin
      step();
      check("cd_pulse", 32'(hit_pulse), 32'd0);
      check("cd_invincible", 32'(invincible), 32'd1);
      check("cd_visible", 32'(player_visible), (((k - 1) / 8) % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("cd_health", 32'(health), 32'd2);

    // Frame 61: ALIVE again, bullet still live and not re-armed
    step();
    check("f61_invincible", 32'(invincible), 32'd0);
    check("f61_visible", 32'(player_visible), 32'd1);
    check("f61_pulse", 32'(hit_pulse), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("noarm_pulse", 32'(hit_pulse), 32'd0);
    end
    check("noarm_health", 32'(health), 32'd2);

    // Re-arm, then hit exactly on the inclusive boundary at X=332
    bullet_on = 1'b0;
    step();
    check("rearm_pulse", 32'(hit_pulse), 32'd0);
    BulletX   = 10'd332;
    bullet_on = 1'b1;
    step();
    check("edge332_pulse", 32'(hit_pulse), 32'd1);
    check("edge332_health", 32'(health), 32'd1);
    check("edge332_invincible", 32'(invincible), 32'd1);

    // Three hits 61 frames apart, health 3,2,1,0
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("r2_health", 32'(health), 32'd3);
    BulletX   = 10'd324;
    bullet_on = 1'b0;
    step();
    for (int h = 0; h < 3; h++) begin
      bullet_on = 1'b1;
      step();
      check("seq_pulse", 32'(hit_pulse), 32'd1);
      check("seq_health", 32'(health), 32'(2 - h));
      if (h < 2) begin
        check("seq_invincible", 32'(invincible), 32'd1);
        bullet_on = 1'b0;
        repeat (60) step();
        check("seq_alive_again", 32'(invincible), 32'd0);
      end else begin
        check("seq_dead", 32'(player_dead), 32'd1);
        check("seq_dead_visible", 32'(player_visible), 32'd0);
        check("seq_dead_invincible", 32'(invincible), 32'd0);
      end
    end

    // Dead: rearm/overlap cycles produce nothing
    for (int i = 0; i < 6; i++) begin
      bullet_on = (i % 2 == 1) ? 1'b1 : 1'b0;
      step();
      check("dead_pulse", 32'(hit_pulse), 32'd0);
    end
    check("dead_health", 32'(health), 32'd0);
    check("dead_hold", 32'(player_dead), 32'd1);

    // Respawn into COOLDOWN with full health
    bullet_on = 1'b1;
    respawn   = 1'b1;
    step();
    respawn = 1'b0;
    check("resp_invincible", 32'(invincible), 32'd1);
    check("resp_dead", 32'(player_dead), 32'd0);
    check("resp_health", 32'(health), 32'd3);
    check("resp_visible", 32'(player_visible), 32'd1);
    step();
    step();
    check("resp_pulse", 32'(hit_pulse), 32'd0);

    // Reset in COOLDOWN with an overlapping live bullet
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rcd_invincible", 32'(invincible), 32'd0);
    check("rcd_dead", 32'(player_dead), 32'd0);
    check("rcd_health", 32'(health), 32'd3);
    check("rcd_pulse", 32'(hit_pulse), 32'd0);
    check("rcd_visible", 32'(player_visible), 32'd1);

    // Reset leaves armed set: the held overlap scores on the next edge
    step();
    check("postrst_pulse", 32'(hit_pulse), 32'd1);
    check("postrst_health", 32'(health), 32'd2);

    // Respawn is ignored while ALIVE
    Reset = 1'b1;
    step();
    Reset     = 1'b0;
    bullet_on = 1'b0;
    respawn   = 1'b1;
    step();
    step();
    respawn = 1'b0;
    check("alive_resp_invincible", 32'(invincible), 32'd0);
    check("alive_resp_health", 32'(health), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_player_hit_tracker

// File: doc/player_hit_tracker.md
PLAYER_HIT_TRACKER -- requirements
Module: player_hit_tracker

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 3, meaning health loaded at reset and respawn (1..7).
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 60, meaning the invincibility window length in frames after a hit or respawn (1..255).
REQ-003 SHALL have parameter BLINK_FRAMES, default 8, meaning the visibility toggle period in frames during cooldown (1..COOLDOWN_FRAMES).
REQ-004 SHALL have port frame_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports BulletX, BulletY, BulletS, input, 10 each, the opponent bullet centre and half-size.
REQ-007 SHALL have port bullet_on, input, 1, high while the opponent bullet is live.
REQ-008 SHALL have ports BallX, BallY, BallS, input, 10 each, the target player centre and half-size.
REQ-009 SHALL have port respawn, input, 1, a level request to revive a dead player.
REQ-010 SHALL have port hit_pulse, output, 1, one-frame strobe per accepted hit.
REQ-011 SHALL have port bullet_kill, output, 1, request to the bullet owner to retire the bullet; equals hit_pulse.
REQ-012 SHALL have port health, output, 3, remaining health.
REQ-013 SHALL have ports invincible, player_dead and player_visible, output, 1 each: in COOLDOWN, in DEAD, and draw-enable respectively.

Function
REQ-014 SHALL compute overlap combinationally in 11-bit unsigned arithmetic, without subtraction, as: BulletX+BulletS+BallS >= BallX, BallX+BallS+BulletS >= BulletX, and both equivalents on Y.
REQ-015 SHALL hold an armed flag: set while bullet_on=0 and cleared on an accepted hit, so that one bullet flight yields at most one hit.
REQ-016 SHALL accept a hit at a rising edge when state=ALIVE, bullet_on=1, armed=1 and overlap=1.
REQ-017 SHALL register hit_pulse=1 for exactly the frame following the accepting edge, giving one-frame latency; health updates on that same edge.
REQ-018 SHALL implement states ALIVE, COOLDOWN and DEAD.
REQ-019 ALIVE with an accepted hit and health>1 SHALL go to COOLDOWN: health-1, cooldown counter loaded with COOLDOWN_FRAMES-1.
REQ-020 ALIVE with an accepted hit and health=1 SHALL go to DEAD with health=0.
REQ-021 COOLDOWN SHALL decrement the counter each frame, ignore all overlaps, and go to ALIVE on the edge where the counter equals 0.
REQ-022 DEAD with respawn=1 SHALL go to COOLDOWN: health=MAX_HEALTH, counter reloaded; DEAD SHALL otherwise hold.
REQ-023 SHALL ignore respawn in ALIVE and COOLDOWN.
REQ-024 SHALL never let health underflow below 0 or exceed MAX_HEALTH.
REQ-025 In COOLDOWN, a blink phase bit SHALL toggle every BLINK_FRAMES frames, starting at 0 on entry.
REQ-026 SHALL drive player_visible as follows: 1 in ALIVE; the inverse of the phase in COOLDOWN; 0 in DEAD.
REQ-027 SHALL drive invincible=(state==COOLDOWN) and player_dead=(state==DEAD), decoded directly from state.
REQ-028 A bullet overlapping on the last COOLDOWN frame with armed=1 SHALL NOT be accepted until the state reads ALIVE on the next edge.

Reset
REQ-029 When Reset=1 at an edge, the block SHALL set state=ALIVE, health=MAX_HEALTH, hit_pulse=0, armed=1, counter=0 and phase=0, so that invincible=0, player_dead=0 and player_visible=1.
REQ-030 Reset SHALL override every simultaneous event, including a hit or respawn, from any state mid-operation.

Structure
REQ-031 SHALL place the state enum (ALIVE, COOLDOWN, DEAD) and the default health and cooldown constants in a shared package hit_pkg.
REQ-032 SHALL implement the overlap test of REQ-014 as sub-module aabb_overlap (purely combinational, 10-bit inputs, 1-bit output), reusable by other collision blocks.

Verification
REQ-033 The bench SHALL drive Ball=(320,240,S=8) and Bullet=(324,240,S=4) with bullet_on=1 for 5 frames, and check: one hit_pulse in frame 2 only, health 3->2, invincible=1.
REQ-034 The bench SHALL drive Bullet=(333,240,S=4) against the same ball, and check: no hit (333 > 320+8+4 fails). At Bullet=(332,240) it SHALL check a hit (boundary inclusive).
REQ-035 The bench SHALL apply three hits separated by 61 frames each with bullet_on dropping between hits, and check: health 3,2,1,0, player_dead=1 after the third hit, and no further pulses.
REQ-036 The bench SHALL hold overlap during COOLDOWN and check: no hit_pulse for 60 frames and player_visible toggling every 8 frames. It SHALL then check: ALIVE on frame 61, with no hit unless bullet_on was re-armed.
REQ-037 The bench SHALL assert respawn=1 in DEAD, then Reset=1 in COOLDOWN with a simultaneous hit, and check: COOLDOWN with health=3 after respawn, then ALIVE, health=3 and hit_pulse=0 the frame after Reset.
